alu_md: RTL and testbench

- Parametrised successor to the single-cycle ALU, with a registered output.
- Adds SLTU and NOR.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, so MULT/MULTU/DIV/DIVU/MTHI/MTLO execute inside the ALU.
- Sits in the EX stage; the pipeline stalls on in_ready=0.

---
 rtl/alu_md_pkg.sv | 23 ++
 rtl/md_iter.sv | 104 ++++++++++
 rtl/alu_md.sv | 121 ++++++++++++
 tb/tb_alu_md.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
// Shared opcode map and multiply/divide sequencer states for the alu_md slice.
package alu_md_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SLT   = 4'h5;
    localparam logic [3:0] OP_SLL   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_SRA   = 4'h8;
    localparam logic [3:0] OP_LUI   = 4'h9;
    localparam logic [3:0] OP_SLTU  = 4'hA;
    localparam logic [3:0] OP_NOR   = 4'hB;
    localparam logic [3:0] OP_MULT  = 4'hC;
    localparam logic [3:0] OP_MULTU = 4'hD;
    localparam logic [3:0] OP_DIV   = 4'hE;
    localparam logic [3:0] OP_DIVU  = 4'hF;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/md_iter.sv
// Iterative multiply/divide datapath: magnitude shift-add multiplier and
// restoring divider, one bit per step, with sign fix-up on the result.
module md_iter #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [SHW:0]       cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH-1:0]   a_raw;
    logic               div_r;
    logic               neg_q;
    logic               neg_r;
    logic               dzero;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;

    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
    assign last  = (cnt == (SHW+1)'(1));

    // Multiply keeps {rem,q} as the running product (q starts as the multiplier);
    // divide shifts the dividend out of q while quotient bits shift in.
    always_comb begin
        sum     = {1'b0, rem} + (q[0] ? {1'b0, mb} : '0);
        shifted = {rem, q[WIDTH-1]};
        trial   = shifted - {1'b0, mb};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            rem   <= '0;
            q     <= '0;
            mb    <= '0;
            a_raw <= '0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dzero <= 1'b0;
        end else if (start) begin
            cnt   <= (SHW+1)'(WIDTH);
            rem   <= '0;
            q     <= mag_a;
            mb    <= mag_b;
            a_raw <= a;
            div_r <= is_div;
            neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= is_signed & a[WIDTH-1];
            dzero <= (b == '0);
        end else if (step) begin
            cnt <= cnt - (SHW+1)'(1);
            if (div_r) begin
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b0};
                end
            end else begin
                rem <= sum[WIDTH:1];
                q   <= {sum[0], q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        prod   = neg_q ? -{rem, q} : {rem, q};
        if (div_r) begin
            if (dzero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -rem : rem;
                res_lo = neg_q ? -q : q;
            end
        end else begin
            {res_hi, res_lo} = prod;
        end
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU with registered result plus an iterative multiply/divide unit
// owning the architectural HI/LO registers.
module alu_md #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             md_done,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import alu_md_pkg::*;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] alu_y;
    logic [SHW-1:0]   shamt;
    logic             is_md;
    logic             accept;
    logic             md_start;
    logic             md_step;
    logic             md_last;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign shamt    = a[SHW-1:0];
    assign is_md    = (op >= OP_MULT);
    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready & ~flush;
    assign md_step  = (state == MUL) || (state == DIV);
    assign md_done  = (state == DONE) && !flush;

    always_comb begin
        alu_y = '0;
        case (op)
            OP_ADD:  alu_y = a + b;
            OP_SUB:  alu_y = a - b;
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_XOR:  alu_y = a ^ b;
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  alu_y = b << shamt;
            OP_SRL:  alu_y = b >> shamt;
            OP_SRA:  alu_y = $signed(b) >>> shamt;
            OP_LUI:  alu_y = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NOR:  alu_y = ~(a | b);
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        state_n  = state;
        md_start = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_md) begin
                    md_start = 1'b1;
                    state_n  = (op == OP_MULT || op == OP_MULTU) ? MUL : DIV;
                end
            end
            MUL, DIV: begin
                if (flush)        state_n = IDLE;
                else if (md_last) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // HI/LO commit at the end of the DONE cycle so a flush there still discards it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            y         <= '0;
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state     <= state_n;
            out_valid <= accept && !is_md;
            if (accept && !is_md) y <= alu_y;
            if (state == DONE) begin
                if (!flush) begin
                    hi <= md_hi;
                    lo <= md_lo;
                end
            end else if (state == IDLE) begin
                if (hi_we) hi <= a;
                if (lo_we) lo <= a;
            end
        end
    end

    md_iter #(.WIDTH(WIDTH)) u_md (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .step      (md_step),
        .is_div    (op == OP_DIV || op == OP_DIVU),
        .is_signed (op == OP_MULT || op == OP_DIV),
        .a         (a),
        .b         (b),
        .last      (md_last),
        .res_hi    (md_hi),
        .res_lo    (md_lo)
    );

endmodule

// File: tb/tb_alu_md.sv
// Randomised and directed bench for alu_md at WIDTH=32, plus a WIDTH=16 instance.
module tb_alu_md;

    import alu_md_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush, in_valid, hi_we, lo_we;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        in_ready, out_valid, md_done;
    logic [31:0] y, hi, lo;

    logic        flush16, in_valid16, hi_we16, lo_we16;
    logic [3:0]  op16;
    logic [15:0] a16, b16;
    logic        in_ready16, out_valid16, md_done16;
    logic [15:0] y16, hi16, lo16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] y_m, hi_m, lo_m;

    alu_md #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .a(a), .b(b), .out_valid(out_valid),
        .y(y), .md_done(md_done), .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo)
    );

    alu_md #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush16), .in_valid(in_valid16),
        .in_ready(in_ready16), .op(op16), .a(a16), .b(b16), .out_valid(out_valid16),
        .y(y16), .md_done(md_done16), .hi_we(hi_we16), .lo_we(lo_we16), .hi(hi16), .lo(lo16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
        int          sx, sz;
        int unsigned sh;
        longint      t;
        sx = x;
        sz = z;
        sh = x[4:0];
        case (o)
            OP_ADD:  return x + z;
            OP_SUB:  return x - z;
            OP_AND:  return x & z;
            OP_OR:   return x | z;
            OP_XOR:  return x ^ z;
            OP_SLT:  return (sx < sz) ? 32'd1 : 32'd0;
            OP_SLL:  begin t = longint'({32'h0, z}) * (longint'(1) << sh); return t[31:0]; end
            OP_SRL:  return z / (32'd1 << sh);
            OP_SRA:  begin t = longint'(sz); t = t >>> sh; return t[31:0]; end
            OP_LUI:  return z * 32'h0001_0000;
            OP_SLTU: return (x < z) ? 32'd1 : 32'd0;
            OP_NOR:  return ~(x | z);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] md_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
        int          sx, sz;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sz = z;
        case (o)
            OP_MULT:  begin sp = longint'(sx) * longint'(sz); return sp; end
            OP_MULTU: begin up = {32'h0, x} * {32'h0, z}; return up; end
            OP_DIV: begin
                if (z == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sz), 32'(sx / sz)};
            end
            OP_DIVU: begin
                if (z == 0) return {x, 32'hFFFF_FFFF};
                return {x % z, x / z};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_single(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
        @(negedge clk);
        op = o; a = x; b = z; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        y_m = alu_ref(o, x, z);
        check($sformatf("out_valid op=%0h", o), out_valid, 1);
        check($sformatf("y op=%0h a=%h b=%h", o, x, z), y, y_m);
    endtask

    task automatic do_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
        logic [63:0] exp;
        int          cyc;
        exp = md_ref(o, x, z);
        @(negedge clk);
        op = o; a = x; b = z; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        check("md no out_valid", out_valid, 0);
        while (!md_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("md_done cycle op=%0h", o), cyc, 33);
        @(posedge clk); #1;
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        check($sformatf("hi op=%0h a=%h b=%h", o, x, z), hi, hi_m);
        check($sformatf("lo op=%0h a=%h b=%h", o, x, z), lo, lo_m);
        check("md in_ready after", in_ready, 1);
        check("md y held", y, y_m);
    endtask

    task automatic do_mt(input logic wh, input logic wl, input logic [31:0] x);
        @(negedge clk);
        a = x; hi_we = wh; lo_we = wl;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (wh) hi_m = x;
        if (wl) lo_m = x;
        check("mthi/mtlo hi", hi, hi_m);
        check("mthi/mtlo lo", lo, lo_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int busy;
        logic [3:0] ro;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0;
        flush16 = 1'b0; in_valid16 = 1'b0; hi_we16 = 1'b0; lo_we16 = 1'b0;
        op16 = '0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset y", y, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset out_valid", out_valid, 0);
        check("reset md_done", md_done, 0);
        check("reset in_ready", in_ready, 1);
        check("reset16 in_ready", in_ready16, 1);
        rst_n = 1'b1;
        y_m = 0; hi_m = 0; lo_m = 0;

        do_single(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        check("ADD result", y, 32'h8000_0000);
        @(posedge clk); #1;
        check("out_valid one-cycle pulse", out_valid, 0);
        check("y held", y, 32'h8000_0000);
        do_single(OP_SLTU, 32'h1, 32'hFFFF_FFFF);
        check("SLTU result", y, 1);
        do_single(OP_NOR, 32'h0, 32'h0);
        check("NOR result", y, 32'hFFFF_FFFF);

        do_md(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("MULT hi", hi, 32'hFFFF_FFFF);
        check("MULT lo", lo, 32'hFFFF_FFFA);
        do_md(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        check("MULTU hi", hi, 32'h2);
        check("MULTU lo", lo, 32'hFFFF_FFFA);
        do_md(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("DIV lo", lo, 32'hFFFF_FFFD);
        check("DIV hi", hi, 32'hFFFF_FFFF);
        do_md(OP_DIVU, 32'd7, 32'd0);
        check("DIVU/0 lo", lo, 32'hFFFF_FFFF);
        check("DIVU/0 hi", hi, 32'd7);
        do_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("DIV ovf lo", lo, 32'h8000_0000);
        check("DIV ovf hi", hi, 32'h0);
        do_md(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        check("DIV/0 hi", hi, 32'hFFFF_FFF9);

        // Back-to-back: DIV then ADD held on in_valid while busy.
        @(negedge clk);
        op = OP_DIV; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        op = OP_ADD; a = 32'd20; b = 32'd22;
        busy = 0;
        while (!in_ready && busy < 100) begin
            busy++;
            @(posedge clk); #1;
        end
        check("b2b busy cycles", busy, 33);
        check("b2b DIV lo", lo, 32'd14);
        check("b2b DIV hi", hi, 32'd2);
        hi_m = 32'd2; lo_m = 32'd14;
        @(posedge clk); #1;
        in_valid = 1'b0;
        y_m = 32'd42;
        check("b2b ADD out_valid", out_valid, 1);
        check("b2b ADD y", y, y_m);

        // MTHI while busy, then flush at cycle 10 of a MULT.
        @(negedge clk);
        op = OP_MULT; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        a = 32'hDEAD_BEEF; hi_we = 1'b1; lo_we = 1'b1;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("MTHI busy hi", hi, hi_m);
        check("MTLO busy lo", lo, lo_m);
        repeat (7) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", in_ready, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_done) cnt++;
            @(posedge clk); #1;
        end
        check("flush md_done count", cnt, 0);
        check("flush hi kept", hi, hi_m);
        check("flush lo kept", lo, lo_m);

        // flush with in_valid in IDLE: not accepted.
        @(negedge clk);
        op = OP_SUB; a = 32'd9; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush idle out_valid", out_valid, 0);
        check("flush idle y", y, y_m);

        // MTHI/MTLO together with an accepted op.
        @(negedge clk);
        op = OP_ADD; a = 32'd5; b = 32'd6; in_valid = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        y_m = 32'd11; hi_m = 32'd5; lo_m = 32'd5;
        check("mt+op y", y, y_m);
        check("mt+op hi", hi, hi_m);
        check("mt+op lo", lo, lo_m);

        for (int i = 0; i < 120; i++) begin
            ro = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) do_mt(1'($urandom), 1'($urandom), $urandom);
            if (ro < OP_MULT) do_single(ro, pick(), pick());
            else do_md(ro, pick(), pick());
        end

        // WIDTH=16 instance.
        @(negedge clk);
        op16 = OP_MULT; a16 = 16'h8000; b16 = 16'h8000; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        cnt = 1;
        while (!md_done16 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("w16 md_done cycle", cnt, 17);
        @(posedge clk); #1;
        check("w16 MULT hi", hi16, 16'h4000);
        check("w16 MULT lo", lo16, 16'h0000);
        @(negedge clk);
        op16 = OP_SRA; a16 = 16'd15; b16 = 16'h8000; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        check("w16 SRA y", y16, 16'hFFFF);
        @(negedge clk);
        op16 = OP_LUI; a16 = 16'd0; b16 = 16'h12AB; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        check("w16 LUI y", y16, 16'hAB00);

        // Reset in the middle of a DIV.
        @(negedge clk);
        op = OP_DIV; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset y", y, 0);
        check("midreset hi", hi, 0);
        check("midreset lo", lo, 0);
        check("midreset out_valid", out_valid, 0);
        check("midreset md_done", md_done, 0);
        check("midreset in_ready", in_ready, 1);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_done) cnt++;
            @(posedge clk); #1;
        end
        check("midreset md_done count", cnt, 0);
        check("midreset hi later", hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
